// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter in front of the SPI slave's single-port register memory.
// Grants either the SPI control path or the local host, round-robin on ties,
// with a burst cap that forces a release when the other side is waiting.
// Memory accesses and read-valid strobes are fully registered.
module spi_mem_arbiter #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              SCLK,
  input  logic              RST,
  input  logic              SPI_REQ,
  input  logic              SPI_WR,
  input  logic [ADDR_W-1:0] SPI_ADDR,
  input  logic [DATA_W-1:0] SPI_WDATA,
  output logic              SPI_GNT,
  output logic              SPI_RVALID,
  input  logic              HOST_REQ,
  input  logic              HOST_WR,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_WDATA,
  output logic              HOST_GNT,
  output logic              HOST_RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam int unsigned      CntW   = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0]  CntMax = CntW'(MAX_BURST);

  typedef enum logic [1:0] {
    StIdle,
    StSpiOwn,
    StHostOwn
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic              last_host_q, last_host_d;

  logic              spi_gnt_q, host_gnt_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  // Issuer of the access currently on the memory bus; routes the read return.
  logic              tag_host_q;
  logic              spi_rvalid_q, host_rvalid_q;

  logic              acc;
  logic              acc_host;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // Saturating burst count after one more accepted access.
  always_comb begin
    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  end

  // Ownership decisions: grant, accept, release.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_host_d = last_host_q;
    acc         = 1'b0;
    acc_host    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // On a tie the side that did not own last wins.
        if (SPI_REQ && (!HOST_REQ || last_host_q)) begin
          state_d     = StSpiOwn;
          last_host_d = 1'b0;
          cnt_d       = '0;
        end else if (HOST_REQ) begin
          state_d     = StHostOwn;
          last_host_d = 1'b1;
          cnt_d       = '0;
        end
      end
      StSpiOwn: begin
        if (!SPI_REQ) begin
          state_d = StIdle;
        end else begin
          acc   = 1'b1;
          cnt_d = cnt_inc;
          if ((cnt_inc == CntMax) && HOST_REQ) begin
            state_d = StIdle;
          end
        end
      end
      StHostOwn: begin
        if (!HOST_REQ) begin
          state_d = StIdle;
        end else begin
          acc      = 1'b1;
          acc_host = 1'b1;
          cnt_d    = cnt_inc;
          if ((cnt_inc == CntMax) && SPI_REQ) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Select the owner's request fields for the access being accepted.
  always_comb begin
    acc_wr    = acc_host ? HOST_WR    : SPI_WR;
    acc_addr  = acc_host ? HOST_ADDR  : SPI_ADDR;
    acc_wdata = acc_host ? HOST_WDATA : SPI_WDATA;
  end

  // State, grants, memory access pipeline and read-return strobes.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_host_q   <= 1'b1;
      spi_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tag_host_q    <= 1'b0;
      spi_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_host_q   <= last_host_d;
      spi_gnt_q     <= (state_d == StSpiOwn);
      host_gnt_q    <= (state_d == StHostOwn);
      mem_en_q      <= acc;
      mem_we_q      <= acc & acc_wr;
      if (acc) begin
        mem_addr_q  <= acc_addr;
        mem_wdata_q <= acc_wdata;
        tag_host_q  <= acc_host;
      end
      spi_rvalid_q  <= mem_en_q & ~mem_we_q & ~tag_host_q;
      host_rvalid_q <= mem_en_q & ~mem_we_q & tag_host_q;
    end
  end

  assign SPI_GNT     = spi_gnt_q;
  assign HOST_GNT    = host_gnt_q;
  assign MEM_EN      = mem_en_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign SPI_RVALID  = spi_rvalid_q;
  assign HOST_RVALID = host_rvalid_q;
  assign RDATA       = MEM_RDATA;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: directed scenarios plus random traffic, every
// cycle compared against a behavioural owner/burst model and a shadow memory.
module tb_spi_mem_arbiter;

  localparam int MAXB = 16;

  logic       SCLK = 1'b0;
  logic       RST;
  logic       SPI_REQ, SPI_WR, HOST_REQ, HOST_WR;
  logic [5:0] SPI_ADDR, HOST_ADDR, MEM_ADDR;
  logic [7:0] SPI_WDATA, HOST_WDATA, MEM_WDATA, RDATA, MEM_RDATA;
  logic       SPI_GNT, SPI_RVALID, HOST_GNT, HOST_RVALID, MEM_EN, MEM_WE;

  spi_mem_arbiter #(
    .ADDR_W   (6),
    .DATA_W   (8),
    .MAX_BURST(MAXB)
  ) dut (
    .SCLK       (SCLK),
    .RST        (RST),
    .SPI_REQ    (SPI_REQ),
    .SPI_WR     (SPI_WR),
    .SPI_ADDR   (SPI_ADDR),
    .SPI_WDATA  (SPI_WDATA),
    .SPI_GNT    (SPI_GNT),
    .SPI_RVALID (SPI_RVALID),
    .HOST_REQ   (HOST_REQ),
    .HOST_WR    (HOST_WR),
    .HOST_ADDR  (HOST_ADDR),
    .HOST_WDATA (HOST_WDATA),
    .HOST_GNT   (HOST_GNT),
    .HOST_RVALID(HOST_RVALID),
    .RDATA      (RDATA),
    .MEM_EN     (MEM_EN),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA)
  );

  always #5 SCLK = ~SCLK;

  // Memory macro: one-cycle read latency.
  logic [7:0] mem [64];
  always @(posedge SCLK) begin
    if (MEM_EN) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
      else        MEM_RDATA     <= mem[MEM_ADDR];
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: owner 0=none 1=spi 2=host; last 1=spi 2=host.
  int         m_own, m_last, m_cnt, e_side;
  logic [7:0] ref_mem [64];
  logic       e_en, e_we, e_srv, e_hrv;
  logic [5:0] e_addr;
  logic [7:0] e_wdata, e_rd_val, e_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("spi_gnt", SPI_GNT, (m_own == 1));
    chk("host_gnt", HOST_GNT, (m_own == 2));
    chk("mem_en", MEM_EN, e_en);
    if (e_en) chk("mem_we", MEM_WE, e_we);
    chk("mem_addr", MEM_ADDR, e_addr);
    chk("mem_wdata", MEM_WDATA, e_wdata);
    chk("spi_rvalid", SPI_RVALID, e_srv);
    chk("host_rvalid", HOST_RVALID, e_hrv);
    if (e_srv || e_hrv) chk("rdata", RDATA, e_rdata);
  endtask

  task automatic issue(input int side, input logic w, input logic [5:0] a, input logic [7:0] d);
    e_en    = 1'b1;
    e_we    = w;
    e_addr  = a;
    e_wdata = d;
    e_side  = side;
    if (w) ref_mem[a] = d;
    else   e_rd_val = ref_mem[a];
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge SCLK);
    m_own = 0; m_last = 2; m_cnt = 0; e_side = 0;
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_srv = 0; e_hrv = 0;
    #1;
    check_all();
    chk("rst_we", MEM_WE, 1'b0);
    RST = 1'b0;
  endtask

  task automatic step(input logic sr, input logic sw, input logic [5:0] sa, input logic [7:0] sd,
                      input logic hr, input logic hw, input logic [5:0] ha,
                      input logic [7:0] hd);
    SPI_REQ = sr;  SPI_WR = sw;  SPI_ADDR = sa;  SPI_WDATA = sd;
    HOST_REQ = hr; HOST_WR = hw; HOST_ADDR = ha; HOST_WDATA = hd;
    @(posedge SCLK);
    // Read issued last cycle returns now, to whoever issued it.
    e_srv   = e_en && !e_we && (e_side == 1);
    e_hrv   = e_en && !e_we && (e_side == 2);
    e_rdata = e_rd_val;
    e_en    = 1'b0;
    e_we    = 1'b0;
    case (m_own)
      0: begin
        if (sr && (!hr || m_last == 2)) begin
          m_own = 1; m_last = 1; m_cnt = 0;
        end else if (hr) begin
          m_own = 2; m_last = 2; m_cnt = 0;
        end
      end
      1: begin
        if (!sr) m_own = 0;
        else begin
          issue(1, sw, sa, sd);
          if (m_cnt < MAXB) m_cnt++;
          if (m_cnt == MAXB && hr) m_own = 0;
        end
      end
      default: begin
        if (!hr) m_own = 0;
        else begin
          issue(2, hw, ha, hd);
          if (m_cnt < MAXB) m_cnt++;
          if (m_cnt == MAXB && sr) m_own = 0;
        end
      end
    endcase
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00);
  endtask

  initial begin
    int n_en, n_low, n_gnt;
    RST = 1'b1;
    SPI_REQ = 0; SPI_WR = 0; SPI_ADDR = 0; SPI_WDATA = 0;
    HOST_REQ = 0; HOST_WR = 0; HOST_ADDR = 0; HOST_WDATA = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    e_rd_val = 0;
    do_reset();

    // SPI write 0x05 <= 0xA5
    step(1, 1, 6'h05, 8'hA5, 0, 0, 6'h00, 8'h00);
    chk("t1_gnt", SPI_GNT, 1'b1);
    step(1, 1, 6'h05, 8'hA5, 0, 0, 6'h00, 8'h00);
    chk("t1_en", MEM_EN, 1'b1);
    chk("t1_we", MEM_WE, 1'b1);
    chk("t1_addr", MEM_ADDR, 6'h05);
    chk("t1_wdata", MEM_WDATA, 8'hA5);
    chk("t1_hgnt", HOST_GNT, 1'b0);
    idle();

    // Host read of 0x05
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h05, 8'h00);
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h05, 8'h00);
    chk("t2_en", MEM_EN, 1'b1);
    chk("t2_we", MEM_WE, 1'b0);
    idle();
    chk("t2_hrv", HOST_RVALID, 1'b1);
    chk("t2_rdata", RDATA, 8'hA5);
    chk("t2_srv", SPI_RVALID, 1'b0);
    idle();

    // Round robin on ties, handover through IDLE
    do_reset();
    step(1, 1, 6'h20, 8'h11, 1, 1, 6'h21, 8'h22);
    chk("t3_tie_spi", SPI_GNT, 1'b1);
    step(1, 1, 6'h20, 8'h11, 1, 1, 6'h21, 8'h22);
    step(0, 0, 6'h00, 8'h00, 1, 1, 6'h21, 8'h22);
    chk("t3_gap", {SPI_GNT, HOST_GNT}, 2'b00);
    step(0, 0, 6'h00, 8'h00, 1, 1, 6'h21, 8'h22);
    chk("t3_host", HOST_GNT, 1'b1);
    idle();
    do_reset();
    step(1, 1, 6'h20, 8'h11, 1, 1, 6'h21, 8'h22);
    idle();
    step(1, 1, 6'h20, 8'h11, 1, 1, 6'h21, 8'h22);
    chk("t3_tie_host", HOST_GNT, 1'b1);
    idle();

    // Burst cap with host waiting
    do_reset();
    n_en = 0; n_low = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 6'(16 + (i % 16)), 8'(i), 1, 1, 6'h30, 8'h77);
      if (MEM_EN && MEM_ADDR[5:4] == 2'b01) n_en++;
      if (!SPI_GNT && !HOST_GNT) n_low++;
    end
    chk("t4_spi_acc", n_en, 16);
    chk("t4_gap", n_low, 1);
    chk("t4_host", HOST_GNT, 1'b1);
    idle();
    // Uncapped burst with host idle
    n_en = 0; n_gnt = 0;
    for (int i = 0; i < 21; i++) begin
      step(1, 1, 6'(16 + (i % 16)), 8'(i + 64), 0, 0, 6'h00, 8'h00);
      if (MEM_EN) n_en++;
      if (SPI_GNT) n_gnt++;
    end
    chk("t4_solo_acc", n_en, 20);
    chk("t4_solo_gnt", n_gnt, 21);
    idle();

    // SPI read returns while ownership moves to host
    step(1, 0, 6'h05, 8'h00, 0, 0, 6'h00, 8'h00);
    step(1, 0, 6'h05, 8'h00, 1, 0, 6'h30, 8'h00);
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h30, 8'h00);
    chk("t5_srv", SPI_RVALID, 1'b1);
    chk("t5_rdata", RDATA, 8'hA5);
    chk("t5_hrv", HOST_RVALID, 1'b0);
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h30, 8'h00);
    chk("t5_srv_once", SPI_RVALID, 1'b0);
    chk("t5_hgnt", HOST_GNT, 1'b1);
    idle();

    // Reset with a host read in flight
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h07, 8'h00);
    step(1, 0, 6'h01, 8'h00, 1, 0, 6'h07, 8'h00);
    do_reset();
    chk("t6_en", MEM_EN, 1'b0);
    idle();
    chk("t6_hrv", HOST_RVALID, 1'b0);
    step(1, 1, 6'h08, 8'h5A, 1, 1, 6'h09, 8'hC3);
    chk("t6_tie_spi", SPI_GNT, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 70, 1'($urandom), 6'($urandom), 8'($urandom),
             $urandom_range(0, 99) < 70, 1'($urandom), 6'($urandom), 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
